// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump resolution: static not-taken, redirect handshake to fetch,
// wrong-path squash, misaligned-target trap and saturating branch statistics.
module branch_redirect_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic             ex_branch,
  input  logic             ex_jump,
  input  logic [2:0]       ex_funct3,
  input  logic             zf,
  input  logic             sf,
  input  logic             vf,
  input  logic             cf,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_target,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             kill_ex,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  misalign_pc,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    TRAP  = 2'd2
  } state_t;

  state_t state;

  logic ex_fire;
  logic cond;
  logic taken;
  logic misaligned;
  logic count_branch;

  assign ex_fire = ex_valid & ~ex_stall & (state == IDLE);

  always_comb begin
    cond = 1'b0;
    case (ex_funct3)
      3'b000:  cond = zf;
      3'b001:  cond = ~zf;
      3'b100:  cond = (sf != vf);
      3'b101:  cond = (sf == vf);
      3'b110:  cond = ~cf;
      3'b111:  cond = cf;
      default: cond = 1'b0;
    endcase
  end

  // A jump wins over the branch condition when both decode bits are set.
  assign taken        = ex_jump | (ex_branch & cond);
  assign misaligned   = (ex_target[1:0] != 2'b00);
  assign count_branch = ex_branch | ex_jump;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      redir_valid  <= 1'b0;
      redir_pc     <= '0;
      flush_ifid   <= 1'b0;
      flush_idex   <= 1'b0;
      kill_ex      <= 1'b0;
      misalign_exc <= 1'b0;
      misalign_pc  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_fire && taken) begin
            flush_ifid <= 1'b1;
            flush_idex <= 1'b1;
            kill_ex    <= 1'b1;
            if (misaligned) begin
              state        <= TRAP;
              misalign_exc <= 1'b1;
              misalign_pc  <= ex_pc;
            end else begin
              state       <= REDIR;
              redir_valid <= 1'b1;
              redir_pc    <= ex_target;
            end
          end
        end
        REDIR: begin
          // redir_pc is left untouched so the target stays stable until accepted.
          if (redir_ready) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
            flush_ifid  <= 1'b0;
            flush_idex  <= 1'b0;
            kill_ex     <= 1'b0;
          end
        end
        TRAP: begin
          state        <= IDLE;
          misalign_exc <= 1'b0;
          flush_ifid   <= 1'b0;
          flush_idex   <= 1'b0;
          kill_ex      <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          redir_valid  <= 1'b0;
          misalign_exc <= 1'b0;
          flush_ifid   <= 1'b0;
          flush_idex   <= 1'b0;
          kill_ex      <= 1'b0;
        end
      endcase
    end
  end

  // Clear beats a same-cycle increment; both counters stick at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_branch <= '0;
      cnt_taken  <= '0;
    end else if (cnt_clr) begin
      cnt_branch <= '0;
      cnt_taken  <= '0;
    end else if (ex_fire) begin
      if (count_branch && (cnt_branch != {CNT_W{1'b1}}))
        cnt_branch <= cnt_branch + CNT_W'(1);
      if (taken && (cnt_taken != {CNT_W{1'b1}}))
        cnt_taken <= cnt_taken + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: sequential vector table plus
// hand-written sequences for stalls, traps, backpressure, reset and saturation.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_stall, ex_branch, ex_jump;
  logic [2:0]  ex_funct3;
  logic        zf, sf, vf, cf;
  logic [31:0] ex_pc, ex_target;
  logic        redir_valid, redir_ready;
  logic [31:0] redir_pc;
  logic        flush_ifid, flush_idex, kill_ex, misalign_exc;
  logic [31:0] misalign_pc;
  logic        cnt_clr;
  logic [15:0] cnt_branch, cnt_taken;

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_funct3(ex_funct3), .zf(zf), .sf(sf), .vf(vf), .cf(cf),
    .ex_pc(ex_pc), .ex_target(ex_target),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .kill_ex(kill_ex),
    .misalign_exc(misalign_exc), .misalign_pc(misalign_pc),
    .cnt_clr(cnt_clr), .cnt_branch(cnt_branch), .cnt_taken(cnt_taken)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, st, br, jp;
    logic [2:0]  f3;
    logic        zf, sf, vf, cf;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_rv, e_fl;
    logic [31:0] e_pc;
    logic [15:0] e_cb, e_ct;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(logic v, logic st, logic br, logic jp, logic [2:0] f3,
                              logic z, logic s, logic o, logic c, logic [31:0] tgt,
                              logic rdy, logic e_rv, logic e_fl, logic [31:0] e_pc,
                              logic [15:0] e_cb, logic [15:0] e_ct);
    vec_t r;
    r.v = v; r.st = st; r.br = br; r.jp = jp; r.f3 = f3;
    r.zf = z; r.sf = s; r.vf = o; r.cf = c; r.tgt = tgt; r.rdy = rdy;
    r.e_rv = e_rv; r.e_fl = e_fl; r.e_pc = e_pc; r.e_cb = e_cb; r.e_ct = e_ct;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ex_valid = 0; ex_stall = 0; ex_branch = 0; ex_jump = 0; ex_funct3 = 3'b000;
    zf = 0; sf = 0; vf = 0; cf = 0; ex_pc = 32'h80; ex_target = 32'h0;
    redir_ready = 1; cnt_clr = 0;
  endtask

  task automatic br_in(input logic [2:0] f3, input logic z, input logic [31:0] tgt);
    ex_valid = 1; ex_branch = 1; ex_jump = 0; ex_funct3 = f3; zf = z; ex_target = tgt;
  endtask

  task automatic chk_flush(input string name, input logic exp);
    chk({name, "_flush_ifid"}, {31'd0, flush_ifid}, {31'd0, exp});
    chk({name, "_flush_idex"}, {31'd0, flush_idex}, {31'd0, exp});
    chk({name, "_kill_ex"},    {31'd0, kill_ex},    {31'd0, exp});
  endtask

  task automatic chk_cnt(input string name, input logic [15:0] cb, input logic [15:0] ct);
    chk({name, "_cnt_branch"}, {16'd0, cnt_branch}, {16'd0, cb});
    chk({name, "_cnt_taken"},  {16'd0, cnt_taken},  {16'd0, ct});
  endtask

  initial begin
    //        v st br jp f3  zf sf vf cf  tgt       rdy rv fl pc        cb  ct
    tbl[0]  = mk(1,0,1,0,3'd0,1,0,0,0, 32'h100,1, 1,1,32'h100, 1, 1); // BEQ taken
    tbl[1]  = mk(1,0,1,0,3'd0,1,0,0,0, 32'h180,1, 0,0,32'h0,   1, 1); // killed in accept cycle
    tbl[2]  = mk(1,0,1,0,3'd6,0,0,0,1, 32'h1c0,1, 0,0,32'h0,   2, 1); // BLTU cf=1 not taken
    tbl[3]  = mk(1,0,1,0,3'd5,0,1,0,0, 32'h1c0,1, 0,0,32'h0,   3, 1); // BGE sf!=vf not taken
    tbl[4]  = mk(1,0,1,0,3'd1,0,0,0,0, 32'h300,0, 1,1,32'h300, 4, 2); // BNE taken
    tbl[5]  = mk(0,0,0,0,3'd0,0,0,0,0, 32'h0,  1, 0,0,32'h0,   4, 2);
    tbl[6]  = mk(1,0,1,0,3'd4,0,1,0,0, 32'h400,1, 1,1,32'h400, 5, 3); // BLT taken
    tbl[7]  = mk(0,0,0,0,3'd0,0,0,0,0, 32'h0,  1, 0,0,32'h0,   5, 3);
    tbl[8]  = mk(1,0,1,0,3'd7,0,0,0,0, 32'h440,1, 0,0,32'h0,   6, 3); // BGEU cf=0 not taken
    tbl[9]  = mk(1,0,1,0,3'd2,1,0,0,0, 32'h440,1, 0,0,32'h0,   7, 3); // funct3 010
    tbl[10] = mk(1,0,0,0,3'd0,1,0,0,0, 32'h480,1, 0,0,32'h0,   7, 3); // non-branch
    tbl[11] = mk(1,0,1,0,3'd0,0,0,0,0, 32'h480,1, 0,0,32'h0,   8, 3); // BEQ zf=0
    tbl[12] = mk(1,0,1,0,3'd6,0,0,0,0, 32'h500,1, 1,1,32'h500, 9, 4); // BLTU taken
    tbl[13] = mk(0,0,0,0,3'd0,0,0,0,0, 32'h0,  1, 0,0,32'h0,   9, 4);
    tbl[14] = mk(1,0,1,1,3'd0,0,0,0,0, 32'h600,1, 1,1,32'h600, 10, 5); // jump+branch => jump
    tbl[15] = mk(0,0,0,0,3'd0,0,0,0,0, 32'h0,  1, 0,0,32'h0,   10, 5);
    tbl[16] = mk(0,0,1,0,3'd0,1,0,0,0, 32'h700,1, 0,0,32'h0,   10, 5); // ex_valid low
    tbl[17] = mk(1,0,1,0,3'd5,0,1,1,0, 32'h700,1, 1,1,32'h700, 11, 6); // BGE sf==vf taken
    tbl[18] = mk(0,0,0,0,3'd0,0,0,0,0, 32'h0,  1, 0,0,32'h0,   11, 6);
    tbl[19] = mk(1,0,1,0,3'd4,0,1,1,0, 32'h740,1, 0,0,32'h0,   12, 6); // BLT sf==vf not taken

    idle_in();
    rst = 0;
    tick(); tick();
    chk("rst_redir_valid", {31'd0, redir_valid}, 32'd0);
    chk("rst_misalign_exc", {31'd0, misalign_exc}, 32'd0);
    chk_flush("rst", 1'b0);
    chk("rst_redir_pc", redir_pc, 32'h0);
    chk("rst_misalign_pc", misalign_pc, 32'h0);
    chk_cnt("rst", 16'd0, 16'd0);
    rst = 1;

    for (int i = 0; i < 20; i++) begin
      ex_valid = tbl[i].v; ex_stall = tbl[i].st; ex_branch = tbl[i].br; ex_jump = tbl[i].jp;
      ex_funct3 = tbl[i].f3; zf = tbl[i].zf; sf = tbl[i].sf; vf = tbl[i].vf; cf = tbl[i].cf;
      ex_target = tbl[i].tgt; redir_ready = tbl[i].rdy;
      tick();
      chk($sformatf("vec%0d_redir_valid", i), {31'd0, redir_valid}, {31'd0, tbl[i].e_rv});
      chk($sformatf("vec%0d_misalign_exc", i), {31'd0, misalign_exc}, 32'd0);
      chk_flush($sformatf("vec%0d", i), tbl[i].e_fl);
      if (tbl[i].e_rv) chk($sformatf("vec%0d_redir_pc", i), redir_pc, tbl[i].e_pc);
      chk_cnt($sformatf("vec%0d", i), tbl[i].e_cb, tbl[i].e_ct);
    end

    // JAL with fetch backpressure for 3 cycles; wrong-path EX traffic ignored.
    idle_in(); cnt_clr = 1; tick(); cnt_clr = 0;
    chk_cnt("clr", 16'd0, 16'd0);
    ex_valid = 1; ex_jump = 1; ex_target = 32'h200; redir_ready = 0;
    tick();
    chk("jal_rv0", {31'd0, redir_valid}, 32'd1);
    chk("jal_pc0", redir_pc, 32'h200);
    for (int k = 0; k < 3; k++) begin
      ex_jump = 0; br_in(3'd0, 1'b1, 32'h900); redir_ready = 0;
      tick();
      chk($sformatf("jal_wait%0d_rv", k), {31'd0, redir_valid}, 32'd1);
      chk($sformatf("jal_wait%0d_pc", k), redir_pc, 32'h200);
      chk_flush($sformatf("jal_wait%0d", k), 1'b1);
    end
    idle_in(); redir_ready = 1;
    tick();
    chk("jal_done_rv", {31'd0, redir_valid}, 32'd0);
    chk_flush("jal_done", 1'b0);
    chk_cnt("jal", 16'd1, 16'd1);

    // Misaligned BNE target: one-cycle trap, no redirect, counted as taken.
    br_in(3'd1, 1'b0, 32'h102); ex_pc = 32'h40; redir_ready = 0;
    tick();
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_pc", misalign_pc, 32'h40);
    chk("mis_rv", {31'd0, redir_valid}, 32'd0);
    chk_flush("mis", 1'b1);
    tick();
    chk("mis_exc_end", {31'd0, misalign_exc}, 32'd0);
    chk_flush("mis_end", 1'b0);
    chk_cnt("mis", 16'd2, 16'd2);
    idle_in(); ex_valid = 1; ex_jump = 1; ex_pc = 32'h44; ex_target = 32'h201;
    tick();
    chk("mis_jal_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_jal_pc", misalign_pc, 32'h44);
    idle_in();
    tick();
    chk("mis_jal_end", {31'd0, misalign_exc}, 32'd0);
    chk_cnt("mis_jal", 16'd3, 16'd3);

    // Stalled taken BEQ: evaluated once, on the first unstalled cycle.
    br_in(3'd0, 1'b1, 32'h104); ex_stall = 1;
    tick();
    chk("stall0_rv", {31'd0, redir_valid}, 32'd0);
    tick();
    chk("stall1_rv", {31'd0, redir_valid}, 32'd0);
    chk_cnt("stall", 16'd3, 16'd3);
    ex_stall = 0;
    tick();
    chk("stall_go_rv", {31'd0, redir_valid}, 32'd1);
    chk("stall_go_pc", redir_pc, 32'h104);
    idle_in();
    tick();
    chk("stall_end_rv", {31'd0, redir_valid}, 32'd0);
    chk_cnt("stall_end", 16'd4, 16'd4);

    // cnt_clr alongside a taken branch: redirect still happens, counters clear.
    br_in(3'd0, 1'b1, 32'h108); cnt_clr = 1;
    tick();
    chk("clrbr_rv", {31'd0, redir_valid}, 32'd1);
    chk_cnt("clrbr", 16'd0, 16'd0);
    idle_in();
    tick();

    // Asynchronous reset in the middle of a redirect.
    br_in(3'd0, 1'b1, 32'h10c); redir_ready = 0;
    tick();
    chk("rstmid_pre_rv", {31'd0, redir_valid}, 32'd1);
    idle_in(); redir_ready = 0;
    rst = 0;
    #1;
    chk("rstmid_rv", {31'd0, redir_valid}, 32'd0);
    chk_flush("rstmid", 1'b0);
    chk("rstmid_pc", redir_pc, 32'h0);
    chk("rstmid_mpc", misalign_pc, 32'h0);
    #2 rst = 1;
    tick();
    chk("rstmid_post_rv", {31'd0, redir_valid}, 32'd0);
    br_in(3'd0, 1'b1, 32'h110); redir_ready = 1;
    tick();
    chk("rstmid_new_rv", {31'd0, redir_valid}, 32'd1);
    chk("rstmid_new_pc", redir_pc, 32'h110);
    idle_in();
    tick();
    chk_cnt("rstmid", 16'd1, 16'd1);

    // Saturation of cnt_branch, then clear with a same-cycle branch.
    cnt_clr = 1; tick(); cnt_clr = 0;
    br_in(3'd2, 1'b0, 32'h0);
    for (int n = 0; n < 65535; n++) tick();
    chk_cnt("sat", 16'hFFFF, 16'd0);
    tick();
    chk_cnt("sat_hold", 16'hFFFF, 16'd0);
    cnt_clr = 1;
    tick();
    chk_cnt("sat_clr", 16'd0, 16'd0);
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Sequencing controller for branch and jump resolution in the EX stage of the pipelined RV32I core. It evaluates the branch condition from the ALU flags and the instruction's funct3 under a static not-taken prediction. On a taken branch or jump it issues a PC redirect to the fetch unit over a valid/ready handshake and squashes wrong-path instructions in IF/ID, ID/EX and EX until fetch accepts the redirect. It also raises misaligned-target traps and keeps saturating branch statistics counters.

## Interface
- XLEN, 32, address/PC width
- CNT_W, 16, statistics counter width

- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  reset: asynchronous, active-low
- ex_valid  in  1  EX stage holds a valid instruction
- ex_stall  in  1  EX stage held by hazard unit; instruction does not advance
- ex_branch  in  1  EX instruction is a conditional branch
- ex_jump  in  1  EX instruction is JAL/JALR (unconditional)
- ex_funct3  in  3  branch funct3
- zf, sf, vf, cf  in  1 each  ALU zero, sign, overflow, carry flags of rs1-rs2
- ex_pc  in  XLEN  PC of EX instruction
- ex_target  in  XLEN  computed branch/jump target
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  XLEN  redirect target
- flush_ifid  out  1  clear IF/ID register
- flush_idex  out  1  clear ID/EX register
- kill_ex  out  1  EX result must not enter EX/MEM
- misalign_exc  out  1  one-cycle instruction-address-misaligned trap pulse
- misalign_pc  out  XLEN  PC of the faulting branch/jump
- cnt_clr  in  1  synchronous clear of both counters
- cnt_branch  out  CNT_W  resolved branches and jumps
- cnt_taken  out  CNT_W  taken branches and jumps

## Operation
- ex_fire = ex_valid & ~ex_stall & (state == IDLE). Evaluation happens only on ex_fire, so each instruction is evaluated once.
- Condition (cond):
  - 000 BEQ: zf
  - 001 BNE: ~zf
  - 100 BLT: sf != vf
  - 101 BGE: sf == vf
  - 110 BLTU: ~cf
  - 111 BGEU: cf
  - 010/011: 0 (not taken, still counted)
- taken = ex_jump | (ex_branch & cond). If ex_jump and ex_branch are both set, the instruction is treated as a jump.
- FSM states: IDLE, REDIR, TRAP.
  - IDLE → TRAP on ex_fire & taken & ex_target[1:0] != 0. Latch misalign_pc = ex_pc.
  - IDLE → REDIR on ex_fire & taken & ex_target[1:0] == 0. Latch redir_pc = ex_target.
  - REDIR → IDLE when redir_valid & redir_ready. Otherwise stay in REDIR; redir_pc is held stable.
  - TRAP → IDLE unconditionally after one cycle. No redirect is issued; the trap unit owns the PC.
- Outputs decode from registered state, not from inputs:
  - REDIR: redir_valid, flush_ifid, flush_idex and kill_ex are all 1.
  - TRAP: misalign_exc, flush_ifid, flush_idex and kill_ex are all 1.
  - IDLE: all four pulse/flush outputs are 0.
- EX instructions presented while not in IDLE are wrong-path. They are ignored: no evaluation, no counting.
- Counters:
  - cnt_branch increments on ex_fire & (ex_branch | ex_jump).
  - cnt_taken increments on ex_fire & taken, including misaligned-target cases.
  - Both saturate at 2^CNT_W-1.
  - cnt_clr has priority over a same-cycle increment.

## Timing
- Reset (rst low, asynchronous): state = IDLE. redir_valid, flush_ifid, flush_idex, kill_ex and misalign_exc are 0. redir_pc, misalign_pc, cnt_branch and cnt_taken are 0. Reset asserted mid-REDIR aborts the redirect immediately.
- Latency: an ex_fire taken in cycle N produces redir_valid (or misalign_exc) and the flushes in cycle N+1.
- Minimum redirect length is one cycle, when redir_ready = 1 in N+1. With redir_ready low for k cycles, the flushes and kill_ex stay high for k+1 cycles.
- Handshake: once asserted, redir_valid stays high with redir_pc constant until accepted. The controller returns to IDLE on the acceptance edge.
- The instruction in EX during the acceptance cycle is still killed. A new ex_fire is possible from cycle acceptance+1.
- A not-taken branch or non-branch instruction causes no state change and no output pulse. The redirect/flush outputs stay 0, and the counters still update per the rules above.
- ex_stall high in cycle N blocks evaluation in N; the instruction is evaluated in the first unstalled cycle.

## Test plan
- BEQ, zf=1, ex_target=0x100, redir_ready=1 → cycle N+1: redir_valid=1, redir_pc=0x100, flush_ifid, flush_idex and kill_ex = 1; cycle N+2: all 0; cnt_branch=1, cnt_taken=1.
- BLTU with cf=1, then BGE with sf=1, vf=0 → both not taken; no flushes; cnt_branch=2, cnt_taken=0.
- JAL to 0x200, redir_ready low for 3 cycles → redir_valid high 4 cycles with redir_pc=0x200; flushes high 4 cycles; ex_valid pulses during the wait are not counted.
- BNE taken, ex_pc=0x40, ex_target=0x102 → misalign_exc one cycle with misalign_pc=0x40; redir_valid stays 0; cnt_taken increments.
- Taken BEQ with ex_stall=1 for 2 cycles → no redirect until the first cycle with ex_stall=0, then redirect one cycle later; counted once.
- Preload cnt_branch to 0xFFFF, then a branch → stays 0xFFFF; cnt_clr together with a branch → 0. rst low during REDIR → redir_valid drops immediately, state is IDLE after release.
